normalization: RTL and testbench

//  Back end of the SD4 MAC datapath: converts the two's-complement fixed-point sum of aligned

---
 rtl/sd4_mac_pkg.sv | 14 +
 rtl/normalization_round_rne.sv | 17 +
 rtl/normalization.sv | 163 ++++++++++++++++
 tb/tb_normalization.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sd4_mac_pkg.sv
// rtl/sd4_mac_pkg.sv - shared constants and FSM state type for the SD4 MAC back end
package sd4_mac_pkg;
    localparam int EXP_W       = 5;
    localparam int EXP_BIAS    = 15;
    localparam int EXP_MAX_FIN = 30;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ABS   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ROUND = 3'd3,
        ST_OUT   = 3'd4
    } norm_state_t;
endpackage

// File: rtl/normalization_round_rne.sv
// rtl/normalization_round_rne.sv - round-to-nearest-even increment of a mantissa field
module round_rne #(
    parameter int MAN_W = 10
) (
    input  logic [MAN_W-1:0] m,
    input  logic             guard,
    input  logic             sticky,
    output logic [MAN_W-1:0] m_rnd,
    output logic             carry
);
    logic inc;

    always_comb begin
        inc            = guard && (sticky || m[0]);
        {carry, m_rnd} = {1'b0, m} + {{MAN_W{1'b0}}, inc};
    end
endmodule

// File: rtl/normalization.sv
// rtl/normalization.sv - iterative normaliser: signed fixed-point sum to sign/exp/mantissa
module normalization
    import sd4_mac_pkg::*;
#(
    parameter int ACC_W   = 20,
    parameter int REF_BIT = 14,
    parameter int MAN_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] acc_in,
    input  logic [EXP_W-1:0] ref_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign_out,
    output logic [EXP_W-1:0] exp_out,
    output logic [MAN_W-1:0] man_out,
    output logic             ovf,
    output logic             unf
);
    localparam logic signed [7:0] E_OFS = 8'(ACC_W - 1 - REF_BIT);
    localparam logic signed [7:0] E_OVF = 8'(2 * EXP_BIAS + 1);
    localparam int              STK_W = ACC_W - 2 - MAN_W;

    norm_state_t       state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [EXP_W-1:0]  ref_q, ref_d;
    logic              sign_q, sign_d;
    logic [ACC_W-1:0]  mag_q, mag_d;
    logic signed [7:0] exp_q, exp_d;
    logic              out_valid_q, out_valid_d;
    logic              sign_out_q, sign_out_d;
    logic [EXP_W-1:0]  exp_out_q, exp_out_d;
    logic [MAN_W-1:0]  man_out_q, man_out_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [MAN_W-1:0]  m_rnd;
    logic              carry;
    logic signed [7:0] e_rnd;

    // Hidden one sits in mag_q[ACC_W-1]; the stored field and guard/sticky follow it.
    round_rne #(.MAN_W(MAN_W)) u_round (
        .m      (mag_q[ACC_W-2 -: MAN_W]),
        .guard  (mag_q[STK_W]),
        .sticky (|mag_q[STK_W-1:0]),
        .m_rnd  (m_rnd),
        .carry  (carry)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ref_d       = ref_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        exp_d       = exp_q;
        out_valid_d = out_valid_q;
        sign_out_d  = sign_out_q;
        exp_out_d   = exp_out_q;
        man_out_d   = man_out_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        e_rnd       = exp_q + $signed({7'b0, carry});

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_d   = acc_in;
                    ref_d   = ref_exp;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = ST_ABS;
                end
            end
            ST_ABS: begin
                sign_d  = acc_q[ACC_W-1];
                // Most negative input wraps to exactly 2^(ACC_W-1) as an unsigned magnitude.
                mag_d   = acc_q[ACC_W-1] ? (~acc_q + ACC_W'(1)) : acc_q;
                exp_d   = $signed({3'b000, ref_q}) + E_OFS;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if ((mag_q == '0) || mag_q[ACC_W-1]) begin
                    state_d = ST_ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 8'sd1;
                end
            end
            ST_ROUND: begin
                if (mag_q == '0) begin
                    sign_out_d = 1'b0;
                    exp_out_d  = '0;
                    man_out_d  = '0;
                end else if (e_rnd >= E_OVF) begin
                    sign_out_d = sign_q;
                    exp_out_d  = EXP_W'(EXP_MAX_FIN);
                    man_out_d  = '1;
                    ovf_d      = 1'b1;
                end else if (e_rnd <= 8'sd0) begin
                    sign_out_d = 1'b0;
                    exp_out_d  = '0;
                    man_out_d  = '0;
                    unf_d      = 1'b1;
                end else begin
                    sign_out_d = sign_q;
                    exp_out_d  = e_rnd[EXP_W-1:0];
                    man_out_d  = m_rnd;
                end
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            ref_q       <= '0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            exp_q       <= '0;
            out_valid_q <= 1'b0;
            sign_out_q  <= 1'b0;
            exp_out_q   <= '0;
            man_out_q   <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ref_q       <= ref_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            out_valid_q <= out_valid_d;
            sign_out_q  <= sign_out_d;
            exp_out_q   <= exp_out_d;
            man_out_q   <= man_out_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign sign_out  = sign_out_q;
    assign exp_out   = exp_out_q;
    assign man_out   = man_out_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
endmodule

// File: tb/tb_normalization.sv
// tb/tb_normalization.sv - directed and random checks of normalization against an arithmetic model
module tb_normalization;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] acc_in = '0;
    logic [4:0]  ref_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sign_out;
    logic [4:0]  exp_out;
    logic [9:0]  man_out;
    logic        ovf;
    logic        unf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    normalization dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_in    (acc_in),
        .ref_exp   (ref_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign_out  (sign_out),
        .exp_out   (exp_out),
        .man_out   (man_out),
        .ovf       (ovf),
        .unf       (unf)
    );

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Value model: |acc| * 2^(ref-14-15), rounded to 11 significant bits, nearest-even.
    task automatic model(input logic [19:0] acc, input int rexp,
                         output int s, output int e_o, output int m_o,
                         output int o_f, output int u_f, output int lat);
        int mag, p, e, m, sh, r, half;
        s = 0; e_o = 0; m_o = 0; o_f = 0; u_f = 0; lat = 3;
        mag = acc[19] ? (1 << 20) - int'(acc) : int'(acc);
        if (mag == 0) return;
        p = 0;
        for (int i = 0; i < 21; i++) if (mag >= (1 << i)) p = i;
        e   = rexp + p - 14;
        lat = 3 + 19 - p;
        if (p > 10) begin
            sh   = p - 10;
            m    = mag >> sh;
            r    = mag - (m << sh);
            half = 1 << (sh - 1);
            if (r > half || (r == half && (m % 2) == 1)) m++;
        end else begin
            m = mag << (10 - p);
        end
        if (m == 2048) begin
            m = 1024;
            e++;
        end
        if (e >= 31) begin
            s = int'(acc[19]); e_o = 30; m_o = 1023; o_f = 1;
        end else if (e <= 0) begin
            u_f = 1;
        end else begin
            s = int'(acc[19]); e_o = e; m_o = m - 1024;
        end
    endtask

    task automatic run_op(input logic [19:0] acc, input int rexp, input int hold);
        int s, e, m, of, uf, lat, cyc;
        model(acc, rexp, s, e, m, of, uf, lat);
        @(negedge clk);
        check("in_ready_before", int'(in_ready), 1);
        in_valid = 1'b1;
        acc_in   = acc;
        ref_exp  = 5'(rexp);
        @(posedge clk);
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) break;
            cyc++;
        end
        check("latency", cyc, lat);
        check("sign", int'(sign_out), s);
        check("exp", int'(exp_out), e);
        check("man", int'(man_out), m);
        check("ovf", int'(ovf), of);
        check("unf", int'(unf), uf);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_exp", int'(exp_out), e);
            check("hold_man", int'(man_out), m);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", int'(out_valid), 0);
        check("in_ready_after", int'(in_ready), 1);
    endtask

    initial begin
        logic [19:0] a;
        int seen;
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_exp", int'(exp_out), 0);
        check("rst_man", int'(man_out), 0);
        rst_n = 1'b1;

        run_op(20'h04000, 15, 0);
        run_op(20'hFC000, 15, 0);
        run_op(20'h80000, 15, 0);
        run_op(20'h04008, 15, 0);
        run_op(20'h04018, 15, 0);
        run_op(20'h07FF8, 15, 0);
        run_op(20'h08000, 30, 0);
        run_op(20'h02000, 1, 0);
        run_op(20'h00000, 7, 0);
        run_op(20'h00001, 20, 5);
        run_op(20'h7FFFF, 31, 0);

        // Reset asserted while the operand is still shifting.
        @(negedge clk);
        in_valid = 1'b1;
        acc_in   = 20'h00001;
        ref_exp  = 5'd10;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("midrst_no_output", seen, 0);

        for (int n = 0; n < 150; n++) begin
            a = 20'($urandom);
            a = $signed(a) >>> $urandom_range(0, 19);
            run_op(a, int'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
